// File: rtl/booth_multiplier_seq.sv
// Sequential radix-2 Booth multiplier, one add/sub-and-shift per clock.
// Define MULT_OVERFLOW_EN to compile in the overflow comparator.
module booth_multiplier_seq #(
  parameter int WIDTH = 32
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  input  logic               is_signed,
  input  logic [WIDTH-1:0]   in1,
  input  logic [WIDTH-1:0]   in2,
  output logic               busy,
  output logic               out_valid,
  output logic [2*WIDTH-1:0] out,
  output logic               overflow
);

  localparam int XW = WIDTH + 1;
  localparam int CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST = CW'(WIDTH);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]         state;
  logic [XW-1:0]      acc;
  logic [XW-1:0]      mq;
  logic [XW-1:0]      mcand;
  logic               q_m1;
  logic [CW-1:0]      cnt;
  logic [XW-1:0]      ext1;
  logic [XW-1:0]      ext2;
  logic [XW-1:0]      acc_sum;
  logic [2*WIDTH-1:0] prod;

  // One extra sign/zero bit lets a single signed datapath cover both modes
  assign ext1 = {is_signed & in1[WIDTH-1], in1};
  assign ext2 = {is_signed & in2[WIDTH-1], in2};

  // Product bits live in the low 2*WIDTH bits of {acc, mq}
  assign prod = {acc[WIDTH-2:0], mq};

  assign busy = (state != S_IDLE);

  // Booth recoding of the current multiplier bit pair
  always_comb begin
    acc_sum = acc;
    unique case (1'b1)
      (!mq[0] &&  q_m1): acc_sum = acc + mcand;
      ( mq[0] && !q_m1): acc_sum = acc - mcand;
      default:           acc_sum = acc;
    endcase
  end

  // Control, datapath and result registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      acc       <= '0;
      mq        <= '0;
      mcand     <= '0;
      q_m1      <= 1'b0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            acc   <= '0;
            mq    <= ext1;
            mcand <= ext2;
            q_m1  <= 1'b0;
            cnt   <= '0;
            state <= S_RUN;
          end
        end
        S_RUN: begin
          {acc, mq, q_m1} <= {acc_sum[XW-1], acc_sum, mq};
          cnt             <= cnt + 1'b1;
          if (cnt == LAST) begin
            state <= S_DONE;
          end
        end
        S_DONE: begin
          out       <= prod;
          out_valid <= 1'b1;
          cnt       <= '0;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef MULT_OVERFLOW_EN
  logic sgn_q;
  logic ovf_calc;
  logic [WIDTH:0]   hi_s;
  logic [WIDTH-1:0] hi_u;

  assign hi_s = prod[2*WIDTH-1:WIDTH-1];
  assign hi_u = prod[2*WIDTH-1:WIDTH];

  // Signed fits when the top WIDTH+1 bits are a pure sign extension
  always_comb begin
    ovf_calc = 1'b0;
    if (sgn_q) begin
      ovf_calc = !((&hi_s) || !(|hi_s));
    end else begin
      ovf_calc = |hi_u;
    end
  end

  // Mode of the operation in flight and the flag registered with out
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sgn_q    <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (state == S_IDLE && start) begin
        sgn_q <= is_signed;
      end
      if (state == S_DONE) begin
        overflow <= ovf_calc;
      end
    end
  end
`else
  assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_booth_multiplier_seq.sv
// Directed and random checks for booth_multiplier_seq.
// Covers WIDTH=32 and WIDTH=8 instances.
module tb_booth_multiplier_seq;

`ifdef MULT_OVERFLOW_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif

  logic        clock;
  logic        reset_n;
  logic        start;
  logic        is_signed;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic        out_valid;
  logic [63:0] out;
  logic        overflow;

  logic        start8;
  logic        sgn8;
  logic [7:0]  a8;
  logic [7:0]  b8;
  logic        busy8;
  logic        vld8;
  logic [15:0] out8;
  logic        ovf8;

  int n_pass;
  int n_total;

  booth_multiplier_seq #(.WIDTH(32)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .is_signed(is_signed), .in1(in1), .in2(in2),
    .busy(busy), .out_valid(out_valid), .out(out),
    .overflow(overflow)
  );

  booth_multiplier_seq #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .start(start8),
    .is_signed(sgn8), .in1(a8), .in2(b8),
    .busy(busy8), .out_valid(vld8), .out(out8),
    .overflow(ovf8)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic do_op(input logic s, input logic [31:0] a,
                       input logic [31:0] b, output int lat,
                       output logic [63:0] p, output logic ov);
    @(negedge clock);
    start = 1'b1; is_signed = s; in1 = a; in2 = b;
    @(posedge clock);
    #1;
    start = 1'b0; is_signed = ~s; in1 = ~a; in2 = b ^ 32'h5a5a_5a5a;
    lat = -1; p = 'x; ov = 1'bx;
    for (int k = 1; k <= 60; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) begin
        lat = k; p = out; ov = overflow;
        break;
      end
    end
  endtask

  task automatic do_op8(input logic s, input logic [7:0] a,
                        input logic [7:0] b, output int lat,
                        output logic [15:0] p, output logic ov);
    @(negedge clock);
    start8 = 1'b1; sgn8 = s; a8 = a; b8 = b;
    @(posedge clock);
    #1;
    start8 = 1'b0; sgn8 = ~s; a8 = ~a; b8 = ~b;
    lat = -1; p = 'x; ov = 1'bx;
    for (int k = 1; k <= 30; k++) begin
      @(posedge clock);
      #1;
      if (vld8) begin
        lat = k; p = out8; ov = ovf8;
        break;
      end
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL reset_busy got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (out !== 64'h0) $display("FAIL reset_out got %h want 0", out);
    else n_pass++;
    n_total++;
    if (overflow !== 1'b0) $display("FAIL reset_ovf got %b want 0", overflow);
    else n_pass++;
    n_total++;
    if (out8 !== 16'h0) $display("FAIL reset_out8 got %h want 0", out8);
    else n_pass++;
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic test_signed_basic;
    int lat; logic [63:0] p; logic ov;
    do_op(1'b1, 32'hFFFF_FFFD, 32'h0000_0007, lat, p, ov);
    n_total++;
    if (lat !== 34) $display("FAIL neg3x7_latency got %0d want 34", lat);
    else n_pass++;
    n_total++;
    if (p !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL neg3x7_out got %h want ffffffffffffffeb", p);
    else n_pass++;
    n_total++;
    if (ov !== 1'b0) $display("FAIL neg3x7_ovf got %b want 0", ov);
    else n_pass++;
    @(posedge clock);
    #1;
    n_total++;
    if (out_valid !== 1'b0) $display("FAIL pulse_width got %b want 0", out_valid);
    else n_pass++;
    n_total++;
    if (out !== 64'hFFFF_FFFF_FFFF_FFEB)
      $display("FAIL out_hold got %h want ffffffffffffffeb", out);
    else n_pass++;
  endtask

  task automatic test_all_ones;
    int lat; logic [63:0] p; logic ov;
    do_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, ov);
    n_total++;
    if (p !== 64'hFFFF_FFFE_0000_0001)
      $display("FAIL uns_ff_out got %h want fffffffe00000001", p);
    else n_pass++;
    n_total++;
    if (ov !== OVF_EN) $display("FAIL uns_ff_ovf got %b want %b", ov, OVF_EN);
    else n_pass++;
    do_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat, p, ov);
    n_total++;
    if (p !== 64'h1) $display("FAIL sgn_ff_out got %h want 1", p);
    else n_pass++;
    n_total++;
    if (ov !== 1'b0) $display("FAIL sgn_ff_ovf got %b want 0", ov);
    else n_pass++;
  endtask

  task automatic test_signed_min;
    int lat; logic [63:0] p; logic ov;
    do_op(1'b1, 32'h8000_0000, 32'h8000_0000, lat, p, ov);
    n_total++;
    if (p !== 64'h4000_0000_0000_0000)
      $display("FAIL min_sq_out got %h want 4000000000000000", p);
    else n_pass++;
    n_total++;
    if (ov !== OVF_EN) $display("FAIL min_sq_ovf got %b want %b", ov, OVF_EN);
    else n_pass++;
    do_op(1'b1, 32'h8000_0000, 32'h0000_0001, lat, p, ov);
    n_total++;
    if (p !== 64'hFFFF_FFFF_8000_0000)
      $display("FAIL min_x1_out got %h want ffffffff80000000", p);
    else n_pass++;
    n_total++;
    if (ov !== 1'b0) $display("FAIL min_x1_ovf got %b want 0", ov);
    else n_pass++;
  endtask

  task automatic test_back_to_back;
    int v1; int v2; logic b1;
    logic [63:0] p1; logic [63:0] p2;
    v1 = -1; v2 = -1; b1 = 1'b0;
    for (int k = 0; k <= 80; k++) begin
      @(negedge clock);
      start = (k <= 68);
      is_signed = 1'b0;
      in1 = 32'(k + 5);
      in2 = 32'(k + 7);
      @(posedge clock);
      #1;
      if (k == 1) b1 = busy;
      if (out_valid && v1 < 0) begin
        v1 = k; p1 = out;
      end else if (out_valid && v2 < 0) begin
        v2 = k; p2 = out;
      end
    end
    start = 1'b0;
    n_total++;
    if (b1 !== 1'b1) $display("FAIL b2b_busy got %b want 1", b1);
    else n_pass++;
    n_total++;
    if (v1 !== 34) $display("FAIL b2b_first_at got %0d want 34", v1);
    else n_pass++;
    n_total++;
    if (p1 !== 64'd35) $display("FAIL b2b_first_out got %0d want 35", p1);
    else n_pass++;
    n_total++;
    if (v2 !== 69) $display("FAIL b2b_second_at got %0d want 69", v2);
    else n_pass++;
    n_total++;
    if (p2 !== 64'd1680) $display("FAIL b2b_second_out got %0d want 1680", p2);
    else n_pass++;
  endtask

  task automatic test_abort;
    int lat; logic [63:0] p; logic ov; logic seen;
    @(negedge clock);
    start = 1'b1; is_signed = 1'b0;
    in1 = 32'h0001_0000; in2 = 32'h0003_0000;
    @(posedge clock);
    #1;
    start = 1'b0;
    repeat (10) @(posedge clock);
    #1;
    reset_n = 1'b0;
    #1;
    n_total++;
    if (busy !== 1'b0) $display("FAIL abort_busy got %b want 0", busy);
    else n_pass++;
    n_total++;
    if (out !== 64'h0) $display("FAIL abort_out got %h want 0", out);
    else n_pass++;
    n_total++;
    if (overflow !== 1'b0) $display("FAIL abort_ovf got %b want 0", overflow);
    else n_pass++;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clock);
      #1;
      if (out_valid) seen = 1'b1;
    end
    n_total++;
    if (seen !== 1'b0) $display("FAIL abort_no_pulse got %b want 0", seen);
    else n_pass++;
    do_op(1'b0, 32'd5, 32'd6, lat, p, ov);
    n_total++;
    if (p !== 64'd30) $display("FAIL post_abort_out got %0d want 30", p);
    else n_pass++;
    n_total++;
    if (lat !== 34) $display("FAIL post_abort_lat got %0d want 34", lat);
    else n_pass++;
  endtask

  task automatic test_width8;
    int lat; logic [15:0] p; logic ov;
    do_op8(1'b0, 8'hFF, 8'hFF, lat, p, ov);
    n_total++;
    if (lat !== 10) $display("FAIL w8_latency got %0d want 10", lat);
    else n_pass++;
    n_total++;
    if (p !== 16'hFE01) $display("FAIL w8_uns_out got %h want fe01", p);
    else n_pass++;
    n_total++;
    if (ov !== OVF_EN) $display("FAIL w8_uns_ovf got %b want %b", ov, OVF_EN);
    else n_pass++;
    do_op8(1'b1, 8'hFD, 8'h07, lat, p, ov);
    n_total++;
    if (p !== 16'hFFEB) $display("FAIL w8_sgn_out got %h want ffeb", p);
    else n_pass++;
    n_total++;
    if (ov !== 1'b0) $display("FAIL w8_sgn_ovf got %b want 0", ov);
    else n_pass++;
  endtask

  task automatic test_random;
    int lat; logic [63:0] p; logic ov;
    logic [31:0] a; logic [31:0] b; logic s;
    longint sa; longint sb; longint sp;
    longint unsigned ua; longint unsigned ub; longint unsigned up;
    logic [63:0] ep; logic eo;
    for (int i = 0; i < 1000; i++) begin
      a = $urandom; b = $urandom; s = 1'($urandom_range(0, 1));
      if (i % 7 == 0) a = {16'(0), a[15:0]};
      if (i % 11 == 0) b = {16'(0), b[15:0]};
      if (s) begin
        sa = longint'($signed(a)); sb = longint'($signed(b));
        sp = sa * sb;
        ep = 64'(sp);
        eo = (sp > 64'sd2147483647) || (sp < -64'sd2147483648);
      end else begin
        ua = {32'h0, a}; ub = {32'h0, b};
        up = ua * ub;
        ep = up;
        eo = (up > 64'h0000_0000_FFFF_FFFF);
      end
      eo = eo & OVF_EN;
      do_op(s, a, b, lat, p, ov);
      n_total++;
      if (p !== ep)
        $display("FAIL rand_out[%0d] s=%b a=%h b=%h got %h want %h",
                 i, s, a, b, p, ep);
      else n_pass++;
      n_total++;
      if (ov !== eo)
        $display("FAIL rand_ovf[%0d] s=%b a=%h b=%h got %b want %b",
                 i, s, a, b, ov, eo);
      else n_pass++;
    end
  endtask

  initial begin
    n_pass = 0; n_total = 0;
    reset_n = 1'b0; start = 1'b0; is_signed = 1'b0;
    in1 = '0; in2 = '0;
    start8 = 1'b0; sgn8 = 1'b0; a8 = '0; b8 = '0;
    test_reset;
    test_signed_basic;
    test_all_ones;
    test_signed_min;
    test_back_to_back;
    test_abort;
    test_width8;
    test_random;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
